// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback path.
package regfile_pkg;

    localparam int RF_RWIDTH = 6;
    localparam int RF_DWIDTH = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_t;

    typedef logic [RF_RWIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_sb.sv
// Pending-write scoreboard: one bit per register plus the output-stage bypass,
// so a write is seen as outstanding until the regfile actually holds it.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int RWIDTH = RF_RWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [RWIDTH-1:0] set_wa,
    input  logic              clr_en,
    input  logic [RWIDTH-1:0] clr_wa,
    input  logic              byp_we,
    input  logic [RWIDTH-1:0] byp_wa,
    input  logic [RWIDTH-1:0] chk_ra1,
    input  logic [RWIDTH-1:0] chk_ra2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREGS = 2 ** RWIDTH;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    // The set is applied after the clear so a new producer issued in the same
    // cycle as the old one retires keeps the register marked busy.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_wa] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_wa] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy1 = (chk_ra1 != '0) &&
                   (pending[chk_ra1] || (byp_we && (byp_wa == chk_ra1)));
    assign busy2 = (chk_ra2 != '0) &&
                   (pending[chk_ra2] || (byp_we && (byp_wa == chk_ra2)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regfile write port and
// exposes RAW-hazard lookups for the issue stage.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int RWIDTH       = RF_RWIDTH,
    parameter int DWIDTH       = RF_DWIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [RWIDTH-1:0] alu_wa,
    input  logic [DWIDTH-1:0] alu_wd,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [RWIDTH-1:0] mem_wa,
    input  logic [DWIDTH-1:0] mem_wd,
    input  logic              iss_valid,
    input  logic [RWIDTH-1:0] iss_wa,
    input  logic [RWIDTH-1:0] chk_ra1,
    input  logic [RWIDTH-1:0] chk_ra2,
    output logic              busy1,
    output logic              busy2,
    output logic              rf_we,
    output logic [RWIDTH-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt;
    logic              starved;
    logic              alu_accept;
    logic              mem_accept;
    wb_src_t           grant;
    logic [RWIDTH-1:0] acc_wa;
    logic [DWIDTH-1:0] acc_wd;

    assign starved = (starve_cnt == LIMIT);

    // Loads normally win; once the ALU has waited long enough the roles swap.
    // Nothing is granted while the block is held in reset.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n) begin
            if (starved) begin
                alu_ready = 1'b1;
                mem_ready = !alu_valid;
            end else begin
                mem_ready = 1'b1;
                alu_ready = !mem_valid;
            end
        end
    end

    assign alu_accept = alu_valid && alu_ready;
    assign mem_accept = mem_valid && mem_ready;

    always_comb begin
        grant  = WB_NONE;
        acc_wa = '0;
        acc_wd = '0;
        if (alu_accept) begin
            grant  = WB_ALU;
            acc_wa = alu_wa;
            acc_wd = alu_wd;
        end else if (mem_accept) begin
            grant  = WB_MEM;
            acc_wa = mem_wa;
            acc_wd = mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_accept) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Writes to r0 are consumed but never reach the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (grant != WB_NONE) begin
            rf_we <= (acc_wa != '0);
            rf_wa <= acc_wa;
            rf_wd <= acc_wd;
        end else begin
            rf_we <= 1'b0;
        end
    end

    rf_scoreboard #(
        .RWIDTH (RWIDTH)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (iss_valid),
        .set_wa  (iss_wa),
        .clr_en  (grant != WB_NONE),
        .clr_wa  (acc_wa),
        .byp_we  (rf_we),
        .byp_wa  (rf_wa),
        .chk_ra1 (chk_ra1),
        .chk_ra2 (chk_ra2),
        .busy1   (busy1),
        .busy2   (busy2)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (`we`/`wa`/`wd`) between two writeback requesters: ALU results and memory-load results.
- Holds a pending-write scoreboard so issue logic can detect RAW hazards on the two read addresses.
- Sits between the execute/memory stages and regfile_32bit, and drives its write port from registered outputs.

Parameters:
- RWIDTH, 6, register address width (2**RWIDTH registers).
- DWIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive stalled ALU cycles before ALU takes priority over MEM; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_wa  in  RWIDTH  ALU destination register
- alu_wd  in  DWIDTH  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load request accepted this cycle
- mem_wa  in  RWIDTH  load destination register
- mem_wd  in  DWIDTH  load data
- iss_valid  in  1  an instruction with a destination is issuing
- iss_wa  in  RWIDTH  destination register of the issuing instruction
- chk_ra1  in  RWIDTH  hazard lookup address 1
- chk_ra2  in  RWIDTH  hazard lookup address 2
- busy1  out  1  chk_ra1 has an outstanding write
- busy2  out  1  chk_ra2 has an outstanding write
- rf_we  out  1  regfile write enable (registered)
- rf_wa  out  RWIDTH  regfile write address (registered)
- rf_wd  out  DWIDTH  regfile write data (registered)

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - Scoreboard all 0; starvation counter 0; priority = MEM.
  - Any in-flight write is dropped.
  - Reset is observable immediately, without a clock edge.
- Arbitration (combinational ready, one grant per cycle):
  - Normal priority:
    - mem_ready = 1.
    - alu_ready = !mem_valid.
  - Starved priority (counter == STARVE_LIMIT):
    - alu_ready = 1.
    - mem_ready = !alu_valid.
  - Accept = valid && ready. At most one accept per cycle.
  - A requester with valid=0 never blocks the other.
- Starvation counter:
  - Increments on each cycle with alu_valid && !alu_ready; saturates at STARVE_LIMIT.
  - Clears on ALU accept or whenever alu_valid=0.
- Output stage (latency 1):
  - On the edge after an accept, rf_we=1 and rf_wa/rf_wd = the winner's wa/wd.
  - With no accept, rf_we=0 and rf_wa/rf_wd hold their values.
  - The regfile commits on the following edge.
- Register 0:
  - A request with wa==0 is accepted normally but produces rf_we=0.
  - It never sets or clears scoreboard bit 0.
  - busy1/busy2 for address 0 are always 0.
- Scoreboard (2**RWIDTH bits):
  - Set: iss_valid && iss_wa!=0 sets pending[iss_wa] on the edge.
  - Clear: an accept with wa!=0 clears pending[wa] on the edge.
  - Same address set and cleared in the same cycle: set wins, because the new producer is outstanding.
  - Sets to an already-pending bit leave it set. There is no counting; issue logic must stall a second producer.
- Hazard outputs (combinational):
  - busyN = pending[chk_raN] || (rf_we && rf_wa==chk_raN && chk_raN!=0).
  - This covers the cycle in which the write sits in the output stage and the regfile does not yet hold it.
- Accepts never occur while rst_n=0.
- A request held across a reset deassert is re-arbitrated from counter 0.

Decomposition:
- Package regfile_pkg holds:
  - localparams RF_RWIDTH=6 and RF_DWIDTH=32.
  - typedef enum logic [1:0] wb_src_t {WB_NONE, WB_ALU, WB_MEM} for the grant.
  - typedef logic [RF_RWIDTH-1:0] reg_addr_t.
- One sub-module: rf_scoreboard.
  - Contains the pending vector, set/clear logic and the two lookups.
  - Input is the arbiter's accept address, plus the output-stage bypass.
- Arbitration, the starvation counter and the output register stay in the top.

Test Plan:
- Reset: drive rst_n=0 mid-stream with rf_we=1 -> rf_we, rf_wa, rf_wd and busy1/2 all 0 immediately; pending cleared.
- Single ALU write: alu_valid=1, alu_wa=5, alu_wd=32'hDEADBEEF -> alu_ready=1 the same cycle; the next cycle gives rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF; the cycle after that gives rf_we=0.
- Contention: mem (wa=3, wd=32'h11) and alu (wa=4, wd=32'h22) valid together -> MEM granted first and ALU the next cycle; rf writes appear in order 3 then 4.
- Starvation: mem_valid held at 1 and alu_valid=1, STARVE_LIMIT=4 -> ALU stalled 4 cycles, granted in cycle 5 with mem_ready=0 that cycle; counter returns to 0.
- Scoreboard:
  - iss_valid with iss_wa=7, then chk_ra1=7 -> busy1=1.
  - ALU writes wa=7 -> busy1 stays 1 through the output-stage cycle, then 0.
  - Simultaneous iss_wa=7 and accept wa=7 -> busy1 stays 1.
- r0 write: alu_wa=0, wd=32'hFFFFFFFF -> alu_ready=1, rf_we stays 0; iss_wa=0 and chk_ra1=0 -> busy1=0.
